plot_receiver: RTL and testbench
================================

PLOT_RECEIVER -- requirements
Module: plot_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered plot requests; power of two, 2..16.
REQ-002 Parameter H_RES, default 160, horizontal pixel count.
REQ-003 Parameter V_RES, default 120, vertical pixel count.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, asynchronous and active-low.
REQ-006 x  input  8  pixel column of the offered plot request.
REQ-007 y  input  7  pixel row of the offered plot request.
REQ-008 colour  input  3  pixel colour of the offered plot request.
REQ-009 plot  input  1  request valid; accepted on an edge where plot && ready.
REQ-010 ready  output  1  receiver can accept a request this cycle.
REQ-011 mem_addr  output  15  framebuffer write address, y*H_RES+x.
REQ-012 mem_data  output  3  framebuffer write colour.
REQ-013 mem_we  output  1  framebuffer write request; held until granted.
REQ-014 mem_grant  input  1  framebuffer consumes the write on an edge where mem_we && mem_grant.
REQ-015 drop_count  output  8  count of rejected out-of-range requests, saturating.
REQ-016 busy  output  1  any request buffered or pending to memory.

Function
REQ-017 ready SHALL equal !full of the FIFO, combinationally; ready SHALL be 0 while resetn is low.
REQ-018 On acceptance, a request with x < H_RES and y < V_RES SHALL be pushed into the FIFO.
REQ-019 On acceptance, a request with x >= H_RES or y >= V_RES SHALL be discarded; drop_count SHALL increment by 1, saturating at 255.
REQ-020 When plot is high and ready is low, the request SHALL be neither stored nor counted; the sender must hold it.
REQ-021 The output stage SHALL be a two-state FSM: EMPTY (mem_we=0) and HOLD (mem_we=1).
REQ-022 EMPTY -> HOLD when the FIFO is non-empty; the head entry SHALL be popped and registered onto mem_addr/mem_data on the same edge.
REQ-023 HOLD with mem_grant=0 SHALL stay in HOLD with mem_addr/mem_data/mem_we unchanged.
REQ-024 HOLD with mem_grant=1 and FIFO non-empty SHALL pop the next entry and remain in HOLD (back-to-back, one write per cycle).
REQ-025 HOLD with mem_grant=1 and FIFO empty SHALL go to EMPTY.
REQ-026 mem_addr SHALL be computed as (y<<7)+(y<<5)+x in 15 bits at register load; maximum value 19199 for default parameters.
REQ-027 Minimum latency: request accepted on edge N SHALL drive mem_we=1 after edge N+1 (FIFO empty, stage EMPTY).
REQ-028 Simultaneous push and pop in one cycle SHALL be supported; occupancy unchanged, order preserved.
REQ-029 When full, a pop on edge N SHALL make ready=1 after edge N; no push occurs on edge N.
REQ-030 Requests SHALL reach memory in acceptance order; no request SHALL be duplicated or lost except per REQ-019.
REQ-031 busy SHALL equal (FIFO non-empty) || mem_we.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with one extra bit to distinguish full from empty.

Reset
REQ-033 resetn low SHALL immediately force: FIFO empty, FSM EMPTY, mem_we=0, mem_addr=0, mem_data=0, drop_count=0, busy=0, ready=0.
REQ-034 Reset asserted mid-operation SHALL discard all buffered and pending requests; no write SHALL complete after reset assertion.
REQ-035 First acceptance SHALL be possible on the first rising edge after resetn deasserts (ready=1).

Verification
REQ-036 Single plot x=5,y=3,colour=3'b101, mem_grant=1 -> one cycle later mem_we=1, mem_addr=485, mem_data=101; mem_we=0 next cycle, busy=0.
REQ-037 mem_grant=0, plot held high with 5 requests -> ready=0 after 4 FIFO entries plus 1 in HOLD (5 accepted total); 6th request stalls; raise mem_grant -> all 5 written in order, one per cycle.
REQ-038 Request x=160,y=0 then x=0,y=120 then x=159,y=119 -> drop_count=2; single write, mem_addr=19199.
REQ-039 300 out-of-range requests -> drop_count saturates at 255; ready stays 1; no mem_we.
REQ-040 Continuous plot with mem_grant=1 every cycle, x=0..15 -> 16 consecutive writes, addresses 0..15, ready never 0.
REQ-041 resetn pulsed low with 3 entries buffered and mem_we=1 -> outputs zero immediately; after release, no stale write appears.

Source files
------------

// File: rtl/plot_receiver.sv
// Buffers pixel plot requests in a small FIFO and issues them to a framebuffer
// one write at a time, dropping (and counting) requests that fall off-screen.
module plot_receiver #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned H_RES      = 160,
    parameter int unsigned V_RES      = 120
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    output logic        ready,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_grant,
    output logic [7:0]  drop_count,
    output logic        busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  DepthC = FIFO_DEPTH[AW:0];
    localparam logic [8:0]   HResC  = H_RES[8:0];
    localparam logic [7:0]   VResC  = V_RES[7:0];
    localparam logic [14:0]  HResA  = H_RES[14:0];

    typedef enum logic {StEmpty, StHold} state_e;

    // Entry layout: {y[6:0], x[7:0], colour[2:0]}
    logic [17:0]   fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_e        state_q, state_d;
    logic [14:0]   addr_q, addr_d;
    logic [2:0]    data_q, data_d;
    logic [7:0]    drop_q, drop_d;

    logic        full, empty, in_range, push, drop, pop;
    logic [17:0] head;
    logic [14:0] head_addr;

    always_comb begin
        full      = (count_q == DepthC);
        empty     = (count_q == '0);
        ready     = resetn && !full;
        in_range  = ({1'b0, x} < HResC) && ({1'b0, y} < VResC);
        push      = plot && ready && in_range;
        drop      = plot && ready && !in_range;
        pop       = !empty && ((state_q == StEmpty) || mem_grant);
        head      = fifo_q[rd_ptr_q];
        head_addr = {8'b0, head[17:11]} * HResA + {7'b0, head[10:3]};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StEmpty: begin
                if (!empty) begin
                    state_d = StHold;
                    addr_d  = head_addr;
                    data_d  = head[2:0];
                end
            end
            StHold: begin
                if (mem_grant) begin
                    if (!empty) begin
                        addr_d = head_addr;
                        data_d = head[2:0];
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StEmpty;
            addr_q   <= '0;
            data_q   <= '0;
            drop_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= {y, x, colour};
            end
        end
    end

    assign mem_we     = (state_q == StHold);
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign drop_count = drop_q;
    assign busy       = !empty || mem_we;

endmodule

// File: tb/tb_plot_receiver.sv
// Directed bench for plot_receiver: reset, latency, back-pressure, range drops,
// saturation, streaming and mid-operation reset.
module tb_plot_receiver;

    logic        clock;
    logic        resetn;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        ready;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_grant;
    logic [7:0]  drop_count;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    plot_receiver dut (
        .clock      (clock),
        .resetn     (resetn),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .ready      (ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_grant  (mem_grant),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic p, input logic [7:0] xv, input logic [6:0] yv,
                         input logic [2:0] cv);
        plot   = p;
        x      = xv;
        y      = yv;
        colour = cv;
    endtask

    int accepted;
    int bad_cycles;

    initial begin
        resetn    = 1'b0;
        mem_grant = 1'b0;
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        #2;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ready), 32'd1);

        // Single plot, minimum latency
        mem_grant = 1'b1;
        drive(1'b1, 8'd5, 7'd3, 3'b101);
        tick();
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        chk("single_we_early", 32'(mem_we), 32'd0);
        chk("single_busy_buf", 32'(busy), 32'd1);
        tick();
        chk("single_we", 32'(mem_we), 32'd1);
        chk("single_addr", 32'(mem_addr), 32'd485);
        chk("single_data", 32'(mem_data), 32'd5);
        tick();
        chk("single_we_off", 32'(mem_we), 32'd0);
        chk("single_busy_off", 32'(busy), 32'd0);

        // Back-pressure: 4 in FIFO + 1 held, sixth stalls
        mem_grant = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 10; c++) begin
            if (accepted < 6) begin
                drive(1'b1, 8'(10 + accepted), 7'd1, 3'(accepted));
            end else begin
                drive(1'b0, 8'd0, 7'd0, 3'd0);
            end
            if (ready && accepted < 6) begin
                accepted++;
            end
            tick();
        end
        chk("bp_accepted", 32'(accepted), 32'd5);
        chk("bp_ready", 32'(ready), 32'd0);
        chk("bp_hold_addr", 32'(mem_addr), 32'd170);
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        tick();
        chk("bp_hold_stable", 32'(mem_addr), 32'd170);
        chk("bp_hold_we", 32'(mem_we), 32'd1);
        mem_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_we_%0d", i), 32'(mem_we), 32'd1);
            chk($sformatf("bp_addr_%0d", i), 32'(mem_addr), 32'(170 + i));
            chk($sformatf("bp_data_%0d", i), 32'(mem_data), 32'(i));
            tick();
            if (i == 0) begin
                chk("bp_ready_after_pop", 32'(ready), 32'd1);
            end
        end
        chk("bp_drain_we", 32'(mem_we), 32'd0);

        // Range checks
        drive(1'b1, 8'd160, 7'd0, 3'd1);
        tick();
        chk("rng_we0", 32'(mem_we), 32'd0);
        drive(1'b1, 8'd0, 7'd120, 3'd2);
        tick();
        chk("rng_we1", 32'(mem_we), 32'd0);
        drive(1'b1, 8'd159, 7'd119, 3'd6);
        tick();
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        chk("rng_drop", 32'(drop_count), 32'd2);
        chk("rng_we2", 32'(mem_we), 32'd0);
        tick();
        chk("rng_we", 32'(mem_we), 32'd1);
        chk("rng_addr", 32'(mem_addr), 32'd19199);
        chk("rng_data", 32'(mem_data), 32'd6);
        tick();
        chk("rng_single", 32'(mem_we), 32'd0);

        // Drop saturation
        bad_cycles = 0;
        drive(1'b1, 8'd200, 7'd5, 3'd3);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!ready || mem_we) begin
                bad_cycles++;
            end
        end
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        chk("sat_drop", 32'(drop_count), 32'd255);
        chk("sat_bad_cycles", 32'(bad_cycles), 32'd0);

        // Streaming, one write per cycle
        bad_cycles = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                drive(1'b1, 8'(i), 7'd0, 3'(i));
            end else begin
                drive(1'b0, 8'd0, 7'd0, 3'd0);
            end
            tick();
            if (!ready) begin
                bad_cycles++;
            end
            if (i >= 1) begin
                chk($sformatf("str_we_%0d", i - 1), 32'(mem_we), 32'd1);
                chk($sformatf("str_addr_%0d", i - 1), 32'(mem_addr), 32'(i - 1));
            end
        end
        chk("str_ready_drops", 32'(bad_cycles), 32'd0);
        tick();
        chk("str_end_we", 32'(mem_we), 32'd0);

        // Reset mid-operation
        mem_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(20 + i), 7'd2, 3'd7);
            tick();
        end
        drive(1'b0, 8'd0, 7'd0, 3'd0);
        chk("mr_we_before", 32'(mem_we), 32'd1);
        chk("mr_addr_before", 32'(mem_addr), 32'd340);
        resetn = 1'b0;
        #1;
        chk("mr_we", 32'(mem_we), 32'd0);
        chk("mr_addr", 32'(mem_addr), 32'd0);
        chk("mr_data", 32'(mem_data), 32'd0);
        chk("mr_ready", 32'(ready), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_drop", 32'(drop_count), 32'd0);
        mem_grant = 1'b1;
        tick();
        resetn = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_we || busy) begin
                bad_cycles++;
            end
        end
        chk("mr_no_stale", 32'(bad_cycles), 32'd0);
        chk("mr_ready_after", 32'(ready), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
